// File: rtl/i2c_slave_target_pkg.sv
// Shared state encoding and bus-level constants for the I2C target.
package i2c_slave_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_slave_target_sync_edge.sv
// Two-flop synchronizer plus previous-value flop; yields level and 1-cycle edge pulses.
module i2c_slave_target_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Preset high: an idle I2C line is pulled up, so reset must not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign lvl_o  = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/i2c_slave_target.sv
// 7-bit-address I2C target with a small byte register file and auto-incrementing pointer.
module i2c_slave_target
    import i2c_slave_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h61,
    parameter int         DEPTH      = 16,
    localparam int        PW         = $clog2(DEPTH)
) (
    input  logic          i2c_core_clk_i,
    input  logic          i2c_core_rst_ni,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    output logic          busy_o,
    output logic          wr_strobe_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_slave_target_sync_edge u_scl (
        .clk(i2c_core_clk_i), .rst_n(i2c_core_rst_ni), .d_i(scl_i),
        .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );
    i2c_slave_target_sync_edge u_sda (
        .clk(i2c_core_clk_i), .rst_n(i2c_core_rst_ni), .d_i(sda_i),
        .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic       start_det, stop_det;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shreg_q[6:0], sda_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_d       = mem_q;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_REG) begin
                                ptr_d   = byte_in[PW-1:0];
                                state_d = ST_REG_ACK;
                            end else begin
                                mem_d[ptr_q] = byte_in;
                                wr_strobe_d  = 1'b1;
                                wr_addr_d    = ptr_q;
                                wr_data_d    = byte_in;
                                ptr_d        = ptr_q + PW'(1);
                                state_d      = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after the byte pulls SDA low; the second ends the ACK clock.
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            oe_d      = 1'b0;
                            if (state_q != ST_ADDR_ACK) begin
                                state_d = ST_WDATA;
                            end else if (shreg_q[0] == I2C_RW_READ) begin
                                state_d = ST_RDATA;
                                shreg_d = mem_q[ptr_q];
                                oe_d    = ~mem_q[ptr_q][7];
                            end else begin
                                state_d = ST_REG;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            oe_d      = 1'b0;
                            ptr_d     = ptr_q + PW'(1);
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            oe_d      = ~shreg_q[6];
                        end
                    end
                end
                // bit_cnt==1 marks "master ACKed, next byte loaded, MSB goes out on next fall".
                ST_RDATA_ACK: begin
                    if (scl_rise && bit_cnt_q == 3'd0) begin
                        if (sda_lvl == I2C_ACK) begin
                            shreg_d   = mem_q[ptr_q];
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 3'd1) begin
                        oe_d      = ~shreg_q[7];
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_IGNORE: oe_d = 1'b0;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni) begin
        if (!i2c_core_rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= '0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            mem_q       <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mem_q       <= mem_d;
        end
    end

    assign sda_oe_o    = oe_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bus-master bench: scoreboarded ACK/read bytes and write strobes against hand-computed values.
module tb_i2c_slave_target;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_w;
    logic       sda_oe_o, busy_o, wr_strobe_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_wr[$];
    logic [8:0]  exp_bus[$];
    logic [8:0]  obs_bus[$];

    assign sda_w = sda_m & ~sda_oe_o;

    i2c_slave_target #(.SLAVE_ADDR(7'h61), .DEPTH(16)) dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_ni(rst_n),
        .scl_i          (scl),
        .sda_i          (sda_w),
        .sda_oe_o       (sda_oe_o),
        .busy_o         (busy_o),
        .wr_strobe_o    (wr_strobe_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        tick(Q); scl = 1'b1;
        tick(Q); s = sda_w;
        tick(Q); scl = 1'b0;
        tick(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input logic [11:0] wr = 12'hfff);
        logic s;
        exp_bus.push_back({1'b1, 7'd0, exp_ack});
        if (wr != 12'hfff) exp_wr.push_back(wr);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        obs_bus.push_back({1'b1, 7'd0, s});
    endtask

    task automatic rd_byte(input logic [7:0] exp_b, input logic ack);
        logic s;
        logic [7:0] v;
        exp_bus.push_back({1'b0, exp_b});
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            v[i] = s;
        end
        clk_bit(ack, s);
        obs_bus.push_back({1'b0, v});
    endtask

    // Scoreboard monitor: write strobes and completed bus bytes are popped against expectations.
    always @(negedge clk) begin
        if (rst_n && wr_strobe_o) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_strobe got addr %h data %h want none", wr_addr_o, wr_data_o);
            end else begin
                logic [11:0] e;
                e = exp_wr.pop_front();
                chk("wr_addr", {28'd0, wr_addr_o}, {28'd0, e[11:8]});
                chk("wr_data", {24'd0, wr_data_o}, {24'd0, e[7:0]});
            end
        end
        while (obs_bus.size() > 0 && exp_bus.size() > 0) begin
            logic [8:0] o, e;
            o = obs_bus.pop_front();
            e = exp_bus.pop_front();
            chk(e[8] ? "ack_bit" : "read_byte", {23'd0, o}, {23'd0, e});
        end
    end

    initial begin
        logic s;
        tick(3);
        #1;
        chk("rst_oe",     {31'd0, sda_oe_o},    32'd0);
        chk("rst_busy",   {31'd0, busy_o},      32'd0);
        chk("rst_strobe", {31'd0, wr_strobe_o}, 32'd0);
        chk("rst_waddr",  {28'd0, wr_addr_o},   32'd0);
        chk("rst_wdata",  {24'd0, wr_data_o},   32'd0);
        rst_n = 1'b1;
        tick(4 * Q);

        // T1 write
        start_c();
        wr_byte(8'hC2, 1'b0);
        chk("t1_busy_hi", {31'd0, busy_o}, 32'd1);
        wr_byte(8'h02, 1'b0);
        wr_byte(8'h0B, 1'b0, {4'd2, 8'h0B});
        wr_byte(8'h0C, 1'b0, {4'd3, 8'h0C});
        wr_byte(8'h0D, 1'b0, {4'd4, 8'h0D});
        stop_c();
        chk("t1_busy_lo", {31'd0, busy_o}, 32'd0);

        // marker at mem[5] to expose the pointer left behind by T2
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h05, 1'b0);
        wr_byte(8'h55, 1'b0, {4'd5, 8'h55});
        stop_c();

        // T2 read with repeated start
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h02, 1'b0);
        start_c();
        wr_byte(8'hC3, 1'b0);
        rd_byte(8'h0B, 1'b0);
        rd_byte(8'h0C, 1'b0);
        rd_byte(8'h0D, 1'b1);
        chk("t2_oe_rel",  {31'd0, sda_oe_o}, 32'd0);
        chk("t2_busy_lo", {31'd0, busy_o},   32'd0);
        stop_c();
        start_c();
        wr_byte(8'hC3, 1'b0);
        rd_byte(8'h55, 1'b1);
        stop_c();

        // T3 wrong address
        start_c();
        wr_byte(8'hC4, 1'b1);
        chk("t3_busy", {31'd0, busy_o}, 32'd0);
        wr_byte(8'h01, 1'b1);
        wr_byte(8'h77, 1'b1);
        stop_c();

        // T4 pointer wrap on write, then read back across the wrap
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h0F, 1'b0);
        wr_byte(8'hAA, 1'b0, {4'd15, 8'hAA});
        wr_byte(8'hBB, 1'b0, {4'd0, 8'hBB});
        stop_c();
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h0F, 1'b0);
        start_c();
        wr_byte(8'hC3, 1'b0);
        rd_byte(8'hAA, 1'b0);
        rd_byte(8'hBB, 1'b0);
        rd_byte(8'h00, 1'b1);
        stop_c();

        // T5 STOP in the middle of a data byte
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h03, 1'b0);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        stop_c();
        chk("t5_oe",   {31'd0, sda_oe_o}, 32'd0);
        chk("t5_busy", {31'd0, busy_o},   32'd0);
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h03, 1'b0);
        start_c();
        wr_byte(8'hC3, 1'b0);
        rd_byte(8'h0C, 1'b1);
        stop_c();

        // T6 reset while the target pulls SDA low for the LSB of 0xAA
        start_c();
        wr_byte(8'hC2, 1'b0);
        wr_byte(8'h0F, 1'b0);
        start_c();
        wr_byte(8'hC3, 1'b0);
        for (int i = 0; i < 7; i++) clk_bit(1'b1, s);
        chk("t6_oe_before", {31'd0, sda_oe_o}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_oe_async", {31'd0, sda_oe_o}, 32'd0);
        chk("t6_busy",     {31'd0, busy_o},   32'd0);
        tick(2);
        #1 rst_n = 1'b1;
        tick(Q);
        start_c();
        wr_byte(8'hC3, 1'b0);
        for (int i = 0; i < 16; i++) rd_byte(8'h00, (i == 15));
        stop_c();

        tick(4);
        chk("wr_queue_drained",  exp_wr.size(),  32'd0);
        chk("bus_queue_drained", exp_bus.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
